// File: rtl/s_fold_pkg.sv
// Shared types and constants for the s_fold_acc frame signature accumulator.
// Fold function F depends on macro S_FOLD_ACC_ROT_EN (rotate-left-by-1 when defined, identity otherwise).
package s_fold_pkg;

    localparam int WORD_W        = 16;
    localparam int CNT_W         = 8;
    localparam int FRAME_LEN_MAX = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    function automatic logic [WORD_W-1:0] fold_f(input logic [WORD_W-1:0] x);
`ifdef S_FOLD_ACC_ROT_EN
        return {x[WORD_W-2:0], x[WORD_W-1]};
`else
        return x;
`endif
    endfunction

endpackage

// File: rtl/s_fold_lane.sv
// One 16-bit signature register: clear has priority over a load of F(sig) ^ din.
module s_fold_lane
    import s_fold_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [WORD_W-1:0] din_i,
    output logic [WORD_W-1:0] sig_o
);

    logic [WORD_W-1:0] sig_q;
    logic [WORD_W-1:0] sig_d;

    // NOTE: default assignment first so every path drives sig_d and no latch is inferred.
    always_comb begin
        sig_d = sig_q;
        if (clr_i) begin
            sig_d = '0;
        end else if (load_i) begin
            sig_d = fold_f(sig_q) ^ din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/s_fold_acc.sv
// Frame signature accumulator: folds FRAME_LEN beats per path into a 16-bit signature.
// Build option: define S_FOLD_ACC_ROT_EN for MISR-style rotate folding, otherwise plain XOR.
module s_fold_acc
    import s_fold_pkg::*;
#(
    parameter int FRAME_LEN = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_aa,
    input  logic [WORD_W-1:0] in_bb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] sig_aa,
    output logic [WORD_W-1:0] sig_bb
);

    // Lengths beyond what the beat counter can reach saturate to its limit.
    localparam int              LEN_INT = (FRAME_LEN > FRAME_LEN_MAX) ? FRAME_LEN_MAX : FRAME_LEN;
    localparam logic [CNT_W-1:0] LEN    = CNT_W'(LEN_INT);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic             accept;
    logic             last_beat;
    logic             sig_clr;

    assign accept    = in_valid & in_ready_q & ~flush;
    assign last_beat = (cnt_q + 8'd1) == LEN;
    assign sig_clr   = flush | (out_valid_q & out_ready);

    // NOTE: sequential state uses non-blocking assignments only; outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACC: begin
                    in_ready_q  <= ~(accept & last_beat);
                    out_valid_q <= accept & last_beat;
                    if (accept) begin
                        cnt_q   <= cnt_q + 8'd1;
                        state_q <= last_beat ? OUT : ACC;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        cnt_q       <= '0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    s_fold_lane u_lane_aa (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (sig_clr),
        .load_i (accept),
        .din_i  (in_aa),
        .sig_o  (sig_aa)
    );

    s_fold_lane u_lane_bb (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (sig_clr),
        .load_i (accept),
        .din_i  (in_bb),
        .sig_o  (sig_bb)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_s_fold_acc.sv
// Self-checking bench for s_fold_acc: three instances (FRAME_LEN 1, 2, 8) against a frame-level fold model.
module tb_s_fold_acc;

    localparam int LENS [3] = '{1, 2, 8};

    logic        clk;
    logic        rst_n;
    logic        flush     [3];
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [15:0] in_aa     [3];
    logic [15:0] in_bb     [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [15:0] sig_aa    [3];
    logic [15:0] sig_bb    [3];

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] q_aa [$];
    logic [15:0] q_bb [$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        s_fold_acc #(.FRAME_LEN(LENS[g])) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_aa     (in_aa[g]),
            .in_bb     (in_bb[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .sig_aa    (sig_aa[g]),
            .sig_bb    (sig_bb[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference fold: signature starts at 0, each beat applies F then XORs the beat in.
    function automatic logic [15:0] model_f(input logic [15:0] x);
`ifdef S_FOLD_ACC_ROT_EN
        return (x << 1) | (x >> 15);
`else
        return x;
`endif
    endfunction

    function automatic logic [15:0] fold_aa();
        logic [15:0] s = 16'h0;
        foreach (q_aa[i]) s = model_f(s) ^ q_aa[i];
        return s;
    endfunction

    function automatic logic [15:0] fold_bb();
        logic [15:0] s = 16'h0;
        foreach (q_bb[i]) s = model_f(s) ^ q_bb[i];
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int k);
        q_aa.delete();
        q_bb.delete();
        for (int i = 0; i < LENS[k]; i++) begin
            q_aa.push_back(16'($urandom));
            q_bb.push_back(16'($urandom));
        end
    endtask

    // Drive the beats held in q_aa/q_bb into instance k, then check the signature and handshake.
    task automatic do_frame(input int k, input int delay, input bit gaps,
                            input logic [15:0] exp_aa, input logic [15:0] exp_bb);
        for (int i = 0; i < LENS[k]; i++) begin
            while (gaps && $urandom_range(0, 3) == 0) begin
                in_valid[k] = 1'b0;
                step();
                n_tests++;
                if (out_valid[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL gap_out_valid dut%0d got %b want 0", k, out_valid[k]);
                end
            end
            in_valid[k] = 1'b1;
            in_aa[k]    = q_aa[i];
            in_bb[k]    = q_bb[i];
            n_tests++;
            if (in_ready[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL beat_in_ready dut%0d beat %0d got %b want 1", k, i, in_ready[k]);
            end
            step();
            if (i < LENS[k] - 1) begin
                n_tests++;
                if (out_valid[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL early_out_valid dut%0d beat %0d got %b want 0", k, i, out_valid[k]);
                end
            end
        end
        // Keep offering junk beats while the result is held; none may be taken.
        in_aa[k] = 16'($urandom);
        in_bb[k] = 16'($urandom);
        n_tests++;
        if (out_valid[k] !== 1'b1 || sig_aa[k] !== exp_aa || sig_bb[k] !== exp_bb || in_ready[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL result dut%0d got ov=%b aa=%h bb=%h rdy=%b want ov=1 aa=%h bb=%h rdy=0",
                     k, out_valid[k], sig_aa[k], sig_bb[k], in_ready[k], exp_aa, exp_bb);
        end
        if (delay > 0) begin
            out_ready[k] = 1'b0;
            for (int c = 0; c < delay; c++) begin
                step();
                n_tests++;
                if (out_valid[k] !== 1'b1 || sig_aa[k] !== exp_aa || sig_bb[k] !== exp_bb || in_ready[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_hold dut%0d cyc %0d got ov=%b aa=%h bb=%h rdy=%b want ov=1 aa=%h bb=%h rdy=0",
                             k, c, out_valid[k], sig_aa[k], sig_bb[k], in_ready[k], exp_aa, exp_bb);
                end
            end
            out_ready[k] = 1'b1;
        end
        step();
        in_valid[k] = 1'b0;
        n_tests++;
        if (out_valid[k] !== 1'b0 || sig_aa[k] !== 16'h0 || sig_bb[k] !== 16'h0 || in_ready[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL after_transfer dut%0d got ov=%b aa=%h bb=%h rdy=%b want ov=0 aa=0 bb=0 rdy=1",
                     k, out_valid[k], sig_aa[k], sig_bb[k], in_ready[k]);
        end
    endtask

    task automatic check_idle_clear(input int k, input string tag, input logic want_rdy);
        n_tests++;
        if (out_valid[k] !== 1'b0 || sig_aa[k] !== 16'h0 || sig_bb[k] !== 16'h0 || in_ready[k] !== want_rdy) begin
            n_fail++;
            $display("FAIL %s dut%0d got ov=%b aa=%h bb=%h rdy=%b want ov=0 aa=0 bb=0 rdy=%b",
                     tag, k, out_valid[k], sig_aa[k], sig_bb[k], in_ready[k], want_rdy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        for (int k = 0; k < 3; k++) check_idle_clear(k, "reset_state", 1'b0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) check_idle_clear(k, "release_before_edge", 1'b0);
        step();
        for (int k = 0; k < 3; k++) check_idle_clear(k, "first_edge_ready", 1'b1);
    endtask

    task automatic test_directed();
        q_aa = '{16'h0001, 16'h0001};
        q_bb = '{16'h8000, 16'h0000};
`ifdef S_FOLD_ACC_ROT_EN
        do_frame(1, 0, 1'b0, 16'h0003, 16'h0001);
`else
        do_frame(1, 0, 1'b0, 16'h0000, 16'h8000);
`endif
    endtask

    task automatic test_stall();
        fill(1);
        do_frame(1, 5, 1'b0, fold_aa(), fold_bb());
        fill(2);
        do_frame(2, 3, 1'b0, fold_aa(), fold_bb());
    endtask

    task automatic test_flush();
        // Flush coincident with the 3rd beat of an 8-beat frame.
        fill(2);
        for (int i = 0; i < 3; i++) begin
            in_valid[2] = 1'b1;
            in_aa[2]    = q_aa[i];
            in_bb[2]    = q_bb[i];
            flush[2]    = (i == 2);
            step();
        end
        flush[2]    = 1'b0;
        in_valid[2] = 1'b0;
        check_idle_clear(2, "flush_mid_frame", 1'b1);
        fill(2);
        do_frame(2, 0, 1'b0, fold_aa(), fold_bb());

        // Flush coincident with an output transfer drops the result.
        fill(1);
        for (int i = 0; i < 2; i++) begin
            in_valid[1] = 1'b1;
            in_aa[1]    = q_aa[i];
            in_bb[1]    = q_bb[i];
            step();
        end
        in_valid[1] = 1'b0;
        flush[1]    = 1'b1;
        step();
        flush[1] = 1'b0;
        check_idle_clear(1, "flush_in_out", 1'b1);
        fill(1);
        do_frame(1, 0, 1'b0, fold_aa(), fold_bb());

        // Flush with a beat in IDLE on a single-beat frame: beat discarded.
        in_valid[0] = 1'b1;
        in_aa[0]    = 16'hBEEF;
        in_bb[0]    = 16'hCAFE;
        flush[0]    = 1'b1;
        step();
        flush[0]    = 1'b0;
        in_valid[0] = 1'b0;
        check_idle_clear(0, "flush_idle_beat", 1'b1);
    endtask

    task automatic test_reset_mid();
        // dut0 sits in OUT (held), dut2 is 3 beats into its frame.
        out_ready[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[0] = (i == 0);
            in_aa[0]    = 16'h5A5A;
            in_bb[0]    = 16'hA5A5;
            in_valid[2] = 1'b1;
            in_aa[2]    = 16'($urandom);
            in_bb[2]    = 16'($urandom);
            step();
        end
        in_valid[0] = 1'b0;
        in_valid[2] = 1'b0;
        n_tests++;
        if (out_valid[0] !== 1'b1 || sig_aa[0] !== 16'h5A5A) begin
            n_fail++;
            $display("FAIL pre_reset_hold dut0 got ov=%b aa=%h want ov=1 aa=5a5a", out_valid[0], sig_aa[0]);
        end
        #3 rst_n = 1'b0;
        #1;
        check_idle_clear(0, "async_reset", 1'b0);
        check_idle_clear(2, "async_reset", 1'b0);
        #1 rst_n = 1'b1;
        out_ready[0] = 1'b1;
        step();
        check_idle_clear(0, "post_reset", 1'b1);
        check_idle_clear(2, "post_reset", 1'b1);
        q_aa = '{16'h1234};
        q_bb = '{16'h00FF};
        do_frame(0, 0, 1'b0, 16'h1234, 16'h00FF);
        fill(2);
        do_frame(2, 0, 1'b0, fold_aa(), fold_bb());
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            fill(2);
            do_frame(2, 0, 1'b0, fold_aa(), fold_bb());
        end
        for (int f = 0; f < 3; f++) begin
            fill(0);
            do_frame(0, 0, 1'b0, fold_aa(), fold_bb());
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 30; f++) begin
            int k;
            k = $urandom_range(0, 2);
            fill(k);
            do_frame(k, $urandom_range(0, 3), 1'b1, fold_aa(), fold_bb());
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            flush[k]     = 1'b0;
            in_valid[k]  = 1'b0;
            in_aa[k]     = 16'h0;
            in_bb[k]     = 16'h0;
            out_ready[k] = 1'b1;
        end
        test_reset();
        test_directed();
        test_stall();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/s_fold_acc.md
S_FOLD_ACC -- requirements
Module: s_fold_acc

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 8: accepted beats per frame; legal range 1..255.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port flush, input, 1 bit: synchronous abort of the current frame.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream folded pair present.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts a beat.
REQ-007 SHALL have port in_aa, input, 16 bits: folded word from the a-path XOR-fold stage.
REQ-008 SHALL have port in_bb, input, 16 bits: folded word from the b-path XOR-fold stage.
REQ-009 SHALL have port out_valid, output, 1 bit: frame signature available.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the signature.
REQ-011 SHALL have port sig_aa, output, 16 bits: a-path signature.
REQ-012 SHALL have port sig_bb, output, 16 bits: b-path signature.

Function
REQ-013 SHALL implement FSM states IDLE, ACC and OUT.
REQ-014 SHALL accept a beat only in the cycle in which in_valid=1 and in_ready=1.
REQ-015 SHALL drive in_ready=1 in IDLE and ACC, and in_ready=0 in OUT.
REQ-016 SHALL update both signatures per beat as sig_x <= F(sig_x) ^ in_x, where F is defined under Configuration.
REQ-017 SHALL treat the signatures as 0 before the first beat of a frame, so the first beat loads F(0)^in_x = in_x.
REQ-018 SHALL move IDLE->ACC on the first beat, or IDLE->OUT on that beat if FRAME_LEN=1.
REQ-019 SHALL hold an 8-bit beat counter that moves ACC->OUT on the beat that makes the count equal FRAME_LEN.
REQ-020 SHALL assert out_valid in the cycle after the final beat is accepted (1-cycle latency), in OUT only.
REQ-021 SHALL keep sig_aa/sig_bb stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on out_valid=1 with out_ready=1, complete the output transfer, clear the signatures and counter, and go to IDLE.
REQ-023 SHALL accept no input beat in the output-transfer cycle; the next frame starts at the earliest one cycle later.
REQ-024 SHALL, when flush=1 in any state, clear the signatures and counter, deassert out_valid, and go to IDLE next cycle.
REQ-025 SHALL give flush priority over a simultaneous input beat (beat discarded) and over a simultaneous output transfer (result dropped).
REQ-026 SHALL not generate stalls or bubbles of its own: in IDLE/ACC a beat every cycle is accepted.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force the following: state=IDLE, counter=0, sig_aa=0, sig_bb=0, out_valid=0, in_ready=0.
REQ-028 SHALL drive in_ready=1 from the first clk edge after rst_n deasserts.
REQ-029 SHALL discard a frame interrupted by reset entirely.

Configuration
REQ-030 SHALL, with macro S_FOLD_ACC_ROT_EN defined, use F(x) = {x[14:0], x[15]}, a rotate left by 1 (MISR-style).
REQ-031 SHALL, without S_FOLD_ACC_ROT_EN, use F(x) = x (plain XOR accumulation); ports and timing are identical in both builds.

Structure
REQ-032 SHALL define the FSM state typedef, the 16-bit word width constant and the FRAME_LEN range limit in shared package s_fold_pkg.
REQ-033 SHALL use one sub-module, s_fold_lane, to hold one 16-bit signature register and its F/XOR update; it SHALL be instantiated twice (aa, bb).

Verification
REQ-034 SHALL cover: FRAME_LEN=2, ROT_EN, beats aa=0x0001, 0x0001 -> sig_aa=0x0003, out_valid 1 cycle after the 2nd beat.
REQ-035 SHALL cover: FRAME_LEN=2, no ROT_EN, same beats -> sig_aa=0x0000; bb=0x8000, 0x0000 -> sig_bb=0x8000.
REQ-036 SHALL cover: ROT_EN, FRAME_LEN=2, bb=0x8000, 0x0000 -> sig_bb=0x0001 (wrap of the rotate).
REQ-037 SHALL cover: out_ready held 0 for 5 cycles -> out_valid and sig stable and in_ready=0 throughout; release -> IDLE with sig=0.
REQ-038 SHALL cover: flush with a simultaneous 3rd beat of an 8-beat frame -> next frame's signature equals its own beats only, with no residue.
REQ-039 SHALL cover: rst_n pulsed low mid-frame asynchronously (between edges) -> outputs 0 immediately; FRAME_LEN=1, beat 0x1234 -> sig_aa=0x1234 next cycle.
